// File: rtl/sram_banked_pkg.sv
// Shared types, limits and the round-robin pick helper for the banked SRAM.
package sram_banked_pkg;

    localparam int MaxPorts = 8;
    localparam int MaxBanks = 16;

    typedef logic [2:0] port_idx_t;
    typedef logic [3:0] bank_sel_t;

    typedef struct packed {
        logic      found;
        port_idx_t idx;
    } rr_pick_t;

    // First requester at index >= ptr, wrapping modulo num_ports.
    function automatic rr_pick_t rr_pick(input logic [MaxPorts-1:0] req,
                                         input port_idx_t ptr,
                                         input int num_ports);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int i = 0; i < MaxPorts; i++) begin
            cand = (int'(ptr) + i) % num_ports;
            if ((i < num_ports) && !res.found && req[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_ram_1p.sv
// Single-port synchronous RAM with bit write mask and one-cycle registered read.
module prim_ram_1p #(
    parameter int    Width       = 32,
    parameter int    Depth       = 128,
    parameter string MemInitFile = "",
    localparam int   Aw          = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             req_i,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Preloaded contents come from the memory flow; the array model stays plain.
    if (MemInitFile != "") begin : g_preloaded
    end

    // Masked write port.
    always_ff @(posedge clk_i) begin
        if (req_i && write_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    // Read port; rdata holds between reads.
    always_ff @(posedge clk_i) begin
        if (req_i && !write_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/sram_banked_arb.sv
// Per-bank round-robin arbiter: one-hot grant among hitting ports, rotating pointer.
module sram_bank_arb
    import sram_banked_pkg::*;
#(
    parameter int NumPorts = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] hit_i,
    output logic [NumPorts-1:0] gnt_o,
    output port_idx_t           winner_o
);

    port_idx_t           ptr_q, ptr_d;
    logic [MaxPorts-1:0] hit_ext;
    rr_pick_t            pick;

    // Winner selection and pointer advance past the winner.
    always_comb begin
        hit_ext                 = '0;
        hit_ext[NumPorts-1:0]   = hit_i;
        pick                    = rr_pick(hit_ext, ptr_q, NumPorts);
        winner_o                = pick.idx;
        for (int p = 0; p < NumPorts; p++) begin
            gnt_o[p] = pick.found && (pick.idx == port_idx_t'(p));
        end
        if (pick.found) begin
            ptr_d = (pick.idx == port_idx_t'(NumPorts - 1)) ? 3'd0 : pick.idx + 3'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_banked.sv
// NumPorts request ports sharing NumBanks word-interleaved single-port banks.
// Optional return-path register stage: define SRAM_BANKED_OUTREG_EN (ReadLatency 2).
module sram_banked
    import sram_banked_pkg::*;
#(
    parameter int    MemSize     = 65536,
    parameter int    Width       = 32,
    parameter int    NumPorts    = 4,
    parameter int    NumBanks    = 4,
    parameter string MemInitFile = "",
    localparam int   Depth       = MemSize / (Width / 8),
    localparam int   Aw          = $clog2(Depth)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            req_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts-1:0][Aw-1:0]    addr_i,
    input  logic [NumPorts-1:0][Width-1:0] wdata_i,
    input  logic [NumPorts-1:0][Width-1:0] wmask_i,
    output logic [NumPorts-1:0]            gnt_o,
    output logic [NumPorts-1:0]            rvalid_o,
    output logic [NumPorts-1:0][Width-1:0] rdata_o,
    output logic [31:0]                    conflict_cnt_o
);

    localparam int BankBits  = $clog2(NumBanks);
    localparam int BankSelW  = (NumBanks > 1) ? BankBits : 1;
    localparam int BankDepth = Depth / NumBanks;
    localparam int RowW      = Aw - BankBits;

    if (((NumBanks & (NumBanks - 1)) != 0) || (NumBanks < 1) || (NumBanks > MaxBanks) ||
        (NumPorts < 1) || (NumPorts > MaxPorts) || ((Width % 8) != 0) ||
        ((MemSize % (NumBanks * Width / 8)) != 0)) begin : g_param_err
        $error("sram_banked: illegal parameter combination");
    end

    logic [NumPorts-1:0][BankSelW-1:0] bsel_s;
    logic [NumPorts-1:0][RowW-1:0]     row_s;

    for (genvar p = 0; p < NumPorts; p++) begin : g_addr
        if (NumBanks > 1) begin : g_split
            assign bsel_s[p] = addr_i[p][BankSelW-1:0];
            assign row_s[p]  = addr_i[p][Aw-1:BankSelW];
        end else begin : g_whole
            assign bsel_s[p] = '0;
            assign row_s[p]  = addr_i[p];
        end
    end

    // Pad per-port fields to MaxPorts so a 3-bit winner index selects them directly.
    logic [MaxPorts-1:0]            we_ext;
    logic [MaxPorts-1:0][RowW-1:0]  row_ext;
    logic [MaxPorts-1:0][Width-1:0] wdata_ext;
    logic [MaxPorts-1:0][Width-1:0] wmask_ext;

    // Port field padding.
    always_comb begin
        we_ext                     = '0;
        row_ext                    = '0;
        wdata_ext                  = '0;
        wmask_ext                  = '0;
        we_ext[NumPorts-1:0]       = we_i;
        row_ext[NumPorts-1:0]      = row_s;
        wdata_ext[NumPorts-1:0]    = wdata_i;
        wmask_ext[NumPorts-1:0]    = wmask_i;
    end

    logic [NumBanks-1:0][NumPorts-1:0] hit_s;
    logic [NumBanks-1:0][NumPorts-1:0] bgnt_s;
    port_idx_t                         win_s [NumBanks];
    logic [Width-1:0]                  brdata_s [2**BankSelW];

    // Which ports target which bank.
    always_comb begin
        hit_s = '0;
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                hit_s[b][p] = req_i[p] && (bsel_s[p] == BankSelW'(b));
            end
        end
    end

    // Each port hits one bank, so OR-ing bank grants yields at most one per port.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NumBanks; b++) begin
            gnt_o = gnt_o | bgnt_s[b];
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        localparam string Suffix =
            (b == 0)  ? "_b0" : (b == 1)  ? "_b1" : (b == 2)  ? "_b2" : (b == 3)  ? "_b3" :
            (b == 4)  ? "_b4" : (b == 5)  ? "_b5" : (b == 6)  ? "_b6" : (b == 7)  ? "_b7" :
            (b == 8)  ? "_b8" : (b == 9)  ? "_b9" : (b == 10) ? "_ba" : (b == 11) ? "_bb" :
            (b == 12) ? "_bc" : (b == 13) ? "_bd" : (b == 14) ? "_be" : "_bf";
        localparam string BankFile = (MemInitFile == "") ? "" : {MemInitFile, Suffix};

        sram_bank_arb #(
            .NumPorts (NumPorts)
        ) u_arb (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .hit_i    (hit_s[b]),
            .gnt_o    (bgnt_s[b]),
            .winner_o (win_s[b])
        );

        prim_ram_1p #(
            .Width       (Width),
            .Depth       (BankDepth),
            .MemInitFile (BankFile)
        ) u_ram (
            .clk_i   (clk_i),
            .req_i   (|bgnt_s[b]),
            .write_i (we_ext[win_s[b]]),
            .addr_i  (row_ext[win_s[b]]),
            .wdata_i (wdata_ext[win_s[b]]),
            .wmask_i (wmask_ext[win_s[b]]),
            .rdata_o (brdata_s[b])
        );
    end

    if (NumBanks == 1) begin : g_pad_rdata
        assign brdata_s[1] = '0;
    end

    logic [NumPorts-1:0]                rvalid_q, rvalid_d;
    logic [NumPorts-1:0][BankSelW-1:0]  bank_q, bank_d;
    logic [NumPorts-1:0][Width-1:0]     hold_q, rdata_s;
    logic [31:0]                        cnt_q, cnt_d;

    // Return path: remember the bank of each granted read; otherwise hold last data.
    always_comb begin
        rvalid_d = gnt_o & ~we_i;
        for (int p = 0; p < NumPorts; p++) begin
            if (rvalid_d[p]) begin
                bank_d[p] = bsel_s[p];
            end else begin
                bank_d[p] = bank_q[p];
            end
            if (rvalid_q[p]) begin
                rdata_s[p] = brdata_s[bank_q[p]];
            end else begin
                rdata_s[p] = hold_q[p];
            end
        end
    end

    // Saturating count of cycles with an unserved request.
    always_comb begin
        if ((|(req_i & ~gnt_o)) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Return-path and counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            bank_q   <= '0;
            hold_q   <= '0;
            cnt_q    <= 32'd0;
        end else begin
            rvalid_q <= rvalid_d;
            bank_q   <= bank_d;
            hold_q   <= rdata_s;
            cnt_q    <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

`ifdef SRAM_BANKED_OUTREG_EN
    logic [NumPorts-1:0]            out_valid_q;
    logic [NumPorts-1:0][Width-1:0] out_data_q;

    // Extra output stage for timing on large banks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rvalid_q;
            out_data_q  <= rdata_s;
        end
    end

    assign rvalid_o = out_valid_q;
    assign rdata_o  = out_data_q;
`else
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_s;
`endif

endmodule
